// File: rtl/rr_arbiter_8_pkg.sv
// Shared types and helpers for the 8-way round-robin arbiter.
// Requester count is fixed at 8 to match the downstream 8-to-3 encoder.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Next requester index, wrapping from the last requester back to 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
);
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [CNT_W-1:0] hold_cnt;

  modport master (output req, input grant, grant_valid, hold_cnt);
  modport slave  (input req, output grant, grant_valid, hold_cnt);
endinterface

// File: rtl/rr_arbiter_8_pick.sv
// Combinational rotating-priority picker: first set bit of req at or after ptr,
// ascending with wrap, returned one-hot.
module rr_pick #(
  parameter int N     = arb_pkg::N_REQ,
  parameter int IDX_W = arb_pkg::IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic             any
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_win;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot = '0;
    for (int j = 0; j < N; j++) begin
      rot[j] = req[IDX_W'((j + int'(ptr)) % N)];
    end
    rot_win = rot & (~rot + N'(1));
    win = '0;
    for (int j = 0; j < N; j++) begin
      win[IDX_W'((j + int'(ptr)) % N)] = rot_win[j];
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, registered one-hot grant with bounded tenure.
// A release re-arbitrates in the same edge so grants hand off without a bubble.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_8_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  state_t           state, state_nxt;
  logic [N-1:0]     grant_q, grant_nxt;
  logic             valid_q;
  logic [IDX_W-1:0] gidx, gidx_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [N-1:0]     pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic [N-1:0]     win;
  logic             any;
  logic             release_g;

  // While granting, the picker only matters on release: it searches past the
  // current owner with the owner's own request masked off.
  assign pick_req = (state == GRANT) ? (bus.req & ~grant_q) : bus.req;
  assign pick_ptr = (state == GRANT) ? next_idx(gidx) : ptr;

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .win (win),
    .any (any)
  );

  assign release_g = (state == GRANT) &&
                     (!bus.req[gidx] || (cnt == CNT_W'(MAX_HOLD - 1)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    grant_nxt = grant_q;
    gidx_nxt  = gidx;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;

    unique case (state)
      IDLE: begin
        if (any) begin
          state_nxt = GRANT;
          grant_nxt = win;
          gidx_nxt  = onehot_to_idx(win);
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (release_g) begin
          ptr_nxt = pick_ptr;
          cnt_nxt = '0;
          if (any) begin
            grant_nxt = win;
            gidx_nxt  = onehot_to_idx(win);
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      gidx    <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      valid_q <= |grant_nxt;
      gidx    <= gidx_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.hold_cnt    = cnt;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed vector table, hand sequences, and random
// stimulus against an index/queue-level reference model, for MAX_HOLD 16, 4, 1.
module tb_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_arbiter_8_if #(.N(8), .MAX_HOLD(16)) b16 ();
  rr_arbiter_8_if #(.N(8), .MAX_HOLD(4))  b4 ();
  rr_arbiter_8_if #(.N(8), .MAX_HOLD(1))  b1 ();

  rr_arbiter_8 #(.N(8), .MAX_HOLD(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
  rr_arbiter_8 #(.N(8), .MAX_HOLD(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
  rr_arbiter_8 #(.N(8), .MAX_HOLD(1))  u1  (.clk(clk), .rst(rst), .bus(b1));

  int total = 0;
  int bad   = 0;

  // Reference model state: current owner index (-1 = none), cycles held,
  // search start pointer, tenure limit.
  int owner[3];
  int held[3];
  int mptr[3];
  int maxh[3] = '{16, 4, 1};

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] exp_grant;
    logic       exp_valid;
    int         exp_hold;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int search(input logic [7:0] v, input int from);
    for (int k = 0; k < 8; k++) begin
      if (v[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_step(input int m, input logic [7:0] rq, input logic r);
    logic [7:0] others;
    if (r) begin
      owner[m] = -1;
      held[m]  = 0;
      mptr[m]  = 0;
    end else if (owner[m] < 0) begin
      owner[m] = search(rq, mptr[m]);
      held[m]  = 0;
    end else if (rq[owner[m]] && held[m] < maxh[m] - 1) begin
      held[m]++;
    end else begin
      others   = rq;
      others[owner[m]] = 1'b0;
      mptr[m]  = (owner[m] + 1) % 8;
      owner[m] = search(others, mptr[m]);
      held[m]  = 0;
    end
  endfunction

  function automatic logic [31:0] model_grant(input int m);
    return (owner[m] < 0) ? 32'd0 : (32'd1 << owner[m]);
  endfunction

  function automatic logic [31:0] dut_grant(input int m);
    case (m)
      0:       return 32'(b16.grant);
      1:       return 32'(b4.grant);
      default: return 32'(b1.grant);
    endcase
  endfunction

  function automatic logic [31:0] dut_valid(input int m);
    case (m)
      0:       return 32'(b16.grant_valid);
      1:       return 32'(b4.grant_valid);
      default: return 32'(b1.grant_valid);
    endcase
  endfunction

  function automatic logic [31:0] dut_hold(input int m);
    case (m)
      0:       return 32'(b16.hold_cnt);
      1:       return 32'(b4.hold_cnt);
      default: return 32'(b1.hold_cnt);
    endcase
  endfunction

  // One clock: the model sees the same req/rst the DUTs sample, outputs are
  // checked 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step(0, b16.req, rst);
    model_step(1, b4.req, rst);
    model_step(2, b1.req, rst);
    #1;
  endtask

  task automatic check_dut(input string tag, input int m, input logic [7:0] g,
                           input logic v, input int h);
    check({tag, " grant"}, dut_grant(m), 32'(g));
    check({tag, " valid"}, dut_valid(m), 32'(v));
    check({tag, " hold"},  dut_hold(m),  32'(h));
  endtask

  task automatic check_model(input int cyc);
    for (int m = 0; m < 3; m++) begin
      string tag;
      tag = $sformatf("rnd c%0d d%0d", cyc, m);
      check({tag, " grant"},  dut_grant(m), model_grant(m));
      check({tag, " valid"},  dut_valid(m), 32'(owner[m] >= 0));
      check({tag, " hold"},   dut_hold(m),  32'(held[m]));
      check({tag, " onehot"}, 32'($onehot0(dut_grant(m))), 32'd1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    b16.req = '0;
    b4.req  = '0;
    b1.req  = '0;
    for (int m = 0; m < 3; m++) begin
      owner[m] = -1;
      held[m]  = 0;
      mptr[m]  = 0;
    end

    // Directed table for MAX_HOLD=16: latency, release, pointer rotation,
    // back-to-back handoff with wrap, ptr wrap 7->0, reset.
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 0};
    tbl[1]  = '{1'b1, 8'h00, 8'h00, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 1'b0, 0};
    tbl[3]  = '{1'b0, 8'h08, 8'h08, 1'b1, 0};
    tbl[4]  = '{1'b0, 8'h08, 8'h08, 1'b1, 1};
    tbl[5]  = '{1'b0, 8'h08, 8'h08, 1'b1, 2};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 1'b0, 0};
    tbl[7]  = '{1'b0, 8'h18, 8'h10, 1'b1, 0};
    tbl[8]  = '{1'b0, 8'h18, 8'h10, 1'b1, 1};
    tbl[9]  = '{1'b0, 8'h08, 8'h08, 1'b1, 0};
    tbl[10] = '{1'b0, 8'h0C, 8'h08, 1'b1, 1};
    tbl[11] = '{1'b0, 8'h04, 8'h04, 1'b1, 0};
    tbl[12] = '{1'b0, 8'h05, 8'h04, 1'b1, 1};
    tbl[13] = '{1'b0, 8'h01, 8'h01, 1'b1, 0};
    tbl[14] = '{1'b0, 8'h00, 8'h00, 1'b0, 0};
    tbl[15] = '{1'b0, 8'h81, 8'h80, 1'b1, 0};
    tbl[16] = '{1'b0, 8'h01, 8'h01, 1'b1, 0};
    tbl[17] = '{1'b1, 8'h01, 8'h00, 1'b0, 0};

    for (int i = 0; i < 18; i++) begin
      rst     = tbl[i].rst;
      b16.req = tbl[i].req;
      cycle();
      check_dut($sformatf("vec%0d", i), 0, tbl[i].exp_grant, tbl[i].exp_valid, tbl[i].exp_hold);
    end

    // Idle after reset for 10 cycles.
    rst     = 1'b0;
    b16.req = '0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      check_dut($sformatf("idle c%0d", c), 0, 8'h00, 1'b0, 0);
    end

    // All requesting: MAX_HOLD=4 rotates every 4 cycles, MAX_HOLD=1 every cycle.
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    b4.req = 8'hFF;
    b1.req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      cycle();
      check_dut($sformatf("fair4 c%0d", c), 1, 8'(1 << ((c / 4) % 8)), 1'b1, c % 4);
      check_dut($sformatf("fair1 c%0d", c), 2, 8'(1 << (c % 8)), 1'b1, 0);
    end
    b4.req = '0;
    b1.req = '0;

    // Sole requester timeout: 16 granted cycles, one idle cycle, re-grant.
    rst = 1'b1;
    cycle();
    rst     = 1'b0;
    b16.req = 8'h40;
    for (int c = 0; c < 18; c++) begin
      cycle();
      if (c < 16)       check_dut($sformatf("tmo c%0d", c), 0, 8'h40, 1'b1, c);
      else if (c == 16) check_dut($sformatf("tmo c%0d", c), 0, 8'h00, 1'b0, 0);
      else              check_dut($sformatf("tmo c%0d", c), 0, 8'h40, 1'b1, 0);
    end

    // Reset mid-grant, then pointer restarts at 0.
    rst = 1'b1;
    cycle();
    rst     = 1'b0;
    b16.req = 8'h10;
    for (int c = 0; c < 8; c++) cycle();
    check_dut("midrst pre", 0, 8'h10, 1'b1, 7);
    rst     = 1'b1;
    b16.req = 8'h11;
    cycle();
    check_dut("midrst rst", 0, 8'h00, 1'b0, 0);
    rst = 1'b0;
    cycle();
    check_dut("midrst post", 0, 8'h01, 1'b1, 0);

    // Random: sticky request patterns with occasional reset, against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) b16.req = 8'($urandom) & 8'($urandom | $urandom);
      if ($urandom_range(0, 3) == 0) b4.req  = 8'($urandom);
      if ($urandom_range(0, 2) == 0) b1.req  = 8'($urandom) & 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
      check_model(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
